sram_controller: RTL and testbench

- Data-memory back end that sits directly downstream of the MEM stage. It replaces single-cycle data memory with an external 16-bit asynchronous SRAM.
- Each 32-bit load or store becomes two 16-bit SRAM accesses: low half first, then high half. Each access is held for a programmable number of wait cycles.
- While an access is in flight it drives `ready` low. The pipeline uses this to freeze every stage register.

---
 rtl/sram_controller_pkg.sv | 46 ++++
 rtl/sram_wait_counter.sv | 33 +++
 rtl/sram_controller.sv | 107 ++++++++++
 tb/tb_sram_controller.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM data-memory back end.
// Contents:
//   - FSM state encodings (legacy 2-bit localparams)
//   - SRAM geometry (half-word address width, data width)
//   - sram_strobe_t : bundle of the active-low SRAM control strobes
//   - sram_req_t    : request fields latched when an access starts
//   - phase_strobes : strobe pattern driven while a half-word phase is active
package sram_controller_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
    } sram_strobe_t;

    typedef struct packed {
        logic                   is_write;
        logic [SRAM_ADDR_W-2:0] word;     // 32-bit word index; LSB of sram_addr selects the half
        logic [31:0]            wdata;
    } sram_req_t;

    localparam sram_strobe_t STROBE_IDLE =
        '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1};

    // Both byte lanes are always enabled: every access is a full half-word.
    function automatic sram_strobe_t phase_strobes(input logic is_write);
        sram_strobe_t s;
        s.ce_n = 1'b0;
        s.oe_n = is_write;
        s.we_n = ~is_write;
        s.ub_n = 1'b0;
        s.lb_n = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter for the SRAM controller.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force count to zero (held while no phase is active)
//   enable    : count this cycle
//   terminal  : count has reached WAIT_CYCLES-1 (last cycle of the phase)
// The counter wraps to zero on its terminal cycle so the next phase starts
// from zero without an extra clear.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    logic [3:0] wcnt;

    assign terminal = (wcnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wcnt <= 4'd0;
        end else if (enable) begin
            wcnt <= terminal ? 4'd0 : wcnt + 4'd1;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// 32-bit load/store port onto a 16-bit asynchronous SRAM.
// Each access runs as two half-word phases (low half, then high half), each
// held for WAIT_CYCLES cycles; `ready` stays low until the access reaches DONE.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   MEM_r_en, MEM_w_en     : load / store request (both set = store)
//   address, write_data    : byte address and store data, latched at start
//   read_data              : registered load result, held between loads
//   ready                  : 0 = freeze the pipeline
//   sram_addr              : half-word address to the SRAM
//   sram_dq_out/oe/in      : data pad out, output enable, in
//   sram_ce_n..sram_lb_n   : active-low SRAM strobes
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_r_en,
    input  logic                   MEM_w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    logic [1:0]   state, state_nxt;
    sram_req_t    req_q;
    sram_strobe_t strobes;
    logic         req, in_phase, active, terminal;
    logic [31:0]  off;
    logic         unused_off;

    assign req        = MEM_r_en | MEM_w_en;
    assign off        = address - 32'(BASE_ADDR);
    assign unused_off = ^{off[31:19], off[1:0]};
    assign in_phase   = (state == ST_LOW) || (state == ST_HIGH);
    // Reset overrides the pads immediately so an interrupted write cannot
    // land another half-word during the reset cycle.
    assign active     = in_phase && !rst;

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .clear    (!in_phase),
        .enable   (in_phase),
        .terminal (terminal)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req)      state_nxt = ST_LOW;
            ST_LOW:  if (terminal) state_nxt = ST_HIGH;
            ST_HIGH: if (terminal) state_nxt = ST_DONE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            read_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req) begin
                req_q.is_write <= MEM_w_en;
                req_q.word     <= off[18:2];
                req_q.wdata    <= write_data;
            end
            // Capture on the last cycle of each phase, when the SRAM has had
            // the full wait time to settle.
            if (!req_q.is_write && terminal) begin
                if (state == ST_LOW)  read_data[15:0]  <= sram_dq_in;
                if (state == ST_HIGH) read_data[31:16] <= sram_dq_in;
            end
        end
    end

    // DONE always releases the pipeline, even with a request still present;
    // the next access is only considered once back in IDLE.
    assign ready = rst || (state == ST_IDLE && !req) || (state == ST_DONE);

    assign strobes     = active ? phase_strobes(req_q.is_write) : STROBE_IDLE;
    assign sram_ce_n   = strobes.ce_n;
    assign sram_oe_n   = strobes.oe_n;
    assign sram_we_n   = strobes.we_n;
    assign sram_ub_n   = strobes.ub_n;
    assign sram_lb_n   = strobes.lb_n;
    assign sram_dq_oe  = active && req_q.is_write;
    assign sram_addr   = active ? {req_q.word, state == ST_HIGH} : '0;
    assign sram_dq_out = !active            ? '0 :
                         (state == ST_HIGH) ? req_q.wdata[31:16] : req_q.wdata[15:0];

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    localparam int BASE = 1024;
    localparam int W    = 2;
    localparam int NC   = 2 * W + 2;   // request cycle + two phases + DONE

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT with WAIT_CYCLES = 2
    logic        rst, r_en, w_en, ready, dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
    logic [31:0] address, write_data, read_data;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;
    // DUT with WAIT_CYCLES = 1
    logic        r_en1, w_en1, ready1, dq_oe1, ce_n1, oe_n1, we_n1, ub_n1, lb_n1;
    logic [31:0] address1, write_data1, read_data1;
    logic [17:0] sram_addr1;
    logic [15:0] dq_out1, dq_in1;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Power-up contents of the SRAM at any half-word address
    function automatic logic [15:0] init_half(input logic [17:0] a);
        return 16'(a[15:0] * 16'h9E37) ^ 16'hC3A5 ^ {14'd0, a[17:16]};
    endfunction

    function automatic logic [16:0] word_of(input logic [31:0] a);
        return 17'((a - 32'(BASE)) / 4);
    endfunction

    function automatic int phase_of(input int c, input int wc);
        if (c == 0)      return 0;   // request seen in IDLE
        if (c <= wc)     return 1;   // low half
        if (c <= 2 * wc) return 2;   // high half
        return 3;                    // DONE
    endfunction

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .MEM_r_en(r_en), .MEM_w_en(w_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(dq_out),
        .sram_dq_oe(dq_oe), .sram_dq_in(dq_in), .sram_ce_n(ce_n),
        .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
    );

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .MEM_r_en(r_en1), .MEM_w_en(w_en1),
        .address(address1), .write_data(write_data1), .read_data(read_data1),
        .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(dq_out1),
        .sram_dq_oe(dq_oe1), .sram_dq_in(dq_in1), .sram_ce_n(ce_n1),
        .sram_oe_n(oe_n1), .sram_we_n(we_n1), .sram_ub_n(ub_n1), .sram_lb_n(lb_n1)
    );

    // SRAM pad model for dut: writable, unwritten cells read their power-up value
    logic [15:0] pad     [0:1023];
    logic        pad_vld [0:1023];
    logic        pad_clr;
    always @(posedge clk) begin
        if (pad_clr) begin
            for (int i = 0; i < 1024; i++) pad_vld[i] <= 1'b0;
        end else if (!ce_n && !we_n) begin
            pad[sram_addr[9:0]]     <= dq_out;
            pad_vld[sram_addr[9:0]] <= 1'b1;
        end
    end
    assign dq_in  = (!ce_n && !oe_n) ?
                    (pad_vld[sram_addr[9:0]] ? pad[sram_addr[9:0]] : init_half(sram_addr)) : 16'hFFFF;
    assign dq_in1 = (!ce_n1 && !oe_n1) ? init_half(sram_addr1) : 16'hFFFF;

    // Word-level reference memory (words 0..255) and expected load result
    logic [31:0] model_mem [0:255];
    logic [31:0] ref_rd;

    // Per-cycle observations of one access on dut
    logic        tr_ready [0:15], tr_ce [0:15], tr_oe [0:15], tr_we [0:15];
    logic        tr_ub [0:15], tr_lb [0:15], tr_dqoe [0:15];
    logic [17:0] tr_addr [0:15];
    logic [15:0] tr_dqo [0:15];
    logic [31:0] tr_rd [0:15];

    // Issue one request on dut at cycle 0, hold it for `hold` cycles, then
    // scramble address/data; record outputs mid-cycle for ncyc cycles.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input int hold, input int ncyc);
        @(negedge clk);
        r_en = rd; w_en = wr; address = a; write_data = d;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            if (c >= hold) begin
                r_en = 1'b0; w_en = 1'b0; address = $urandom; write_data = $urandom;
            end
            #2;
            tr_ready[c] = ready; tr_ce[c] = ce_n; tr_oe[c] = oe_n; tr_we[c] = we_n;
            tr_ub[c] = ub_n; tr_lb[c] = lb_n; tr_dqoe[c] = dq_oe;
            tr_addr[c] = sram_addr; tr_dqo[c] = dq_out; tr_rd[c] = read_data;
        end
        r_en = 1'b0; w_en = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        pad_clr = 1'b0;
        #2;
        cmp_cnt++; if (ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got %b want 1", ready); end
        cmp_cnt++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'h1F) begin
            err_cnt++; $display("FAIL reset_strobes got %b want 11111", {ce_n, oe_n, we_n, ub_n, lb_n}); end
        cmp_cnt++; if (dq_oe !== 1'b0 || sram_addr !== 18'd0) begin
            err_cnt++; $display("FAIL reset_pads got oe=%b addr=%h want 0/0", dq_oe, sram_addr); end
        cmp_cnt++; if (read_data !== 32'd0) begin err_cnt++; $display("FAIL reset_rdata got %h want 0", read_data); end
        @(negedge clk); rst = 1'b0; #2;
        cmp_cnt++; if (ready !== 1'b0) begin err_cnt++; $display("FAIL reset_first_req got %b want 0", ready); end
        @(negedge clk); r_en = 1'b0; #2;
        cmp_cnt++; if (oe_n !== 1'b0 || ready !== 1'b0) begin
            err_cnt++; $display("FAIL reset_read_start got oe_n=%b ready=%b want 0/0", oe_n, ready); end
        for (int c = 2; c < NC; c++) @(negedge clk);
        #2;
        cmp_cnt++; if (ready !== 1'b1 || read_data !== model_mem[0]) begin
            err_cnt++; $display("FAIL reset_read_done got rdy=%b rd=%h want 1/%h", ready, read_data, model_mem[0]); end
        ref_rd = model_mem[0];
    endtask

    task automatic test_write;
        logic [31:0] d = 32'hDEADBEEF;
        int ph; logic act;
        run_access(1'b0, 1'b1, 32'd1028, d, 1, NC);
        for (int c = 0; c < NC; c++) begin
            ph = phase_of(c, W); act = (ph == 1 || ph == 2);
            cmp_cnt++; if (tr_ready[c] !== (ph == 3)) begin
                err_cnt++; $display("FAIL write_ready c=%0d got %b want %b", c, tr_ready[c], ph == 3); end
            cmp_cnt++; if (tr_we[c] !== !act || tr_dqoe[c] !== act) begin
                err_cnt++; $display("FAIL write_we c=%0d got we_n=%b oe=%b want %b/%b", c, tr_we[c], tr_dqoe[c], !act, act); end
            cmp_cnt++; if (tr_addr[c] !== (ph == 1 ? 18'd2 : ph == 2 ? 18'd3 : 18'd0)) begin
                err_cnt++; $display("FAIL write_addr c=%0d got %h", c, tr_addr[c]); end
            cmp_cnt++; if (tr_dqo[c] !== (ph == 1 ? 16'hBEEF : ph == 2 ? 16'hDEAD : 16'h0)) begin
                err_cnt++; $display("FAIL write_dq c=%0d got %h", c, tr_dqo[c]); end
            cmp_cnt++; if ({tr_ce[c], tr_ub[c], tr_lb[c], tr_oe[c]} !== {!act, !act, !act, 1'b1}) begin
                err_cnt++; $display("FAIL write_strobes c=%0d got %b", c, {tr_ce[c], tr_ub[c], tr_lb[c], tr_oe[c]}); end
        end
        cmp_cnt++; if (tr_rd[NC-1] !== ref_rd) begin
            err_cnt++; $display("FAIL write_rdata got %h want %h", tr_rd[NC-1], ref_rd); end
        model_mem[1] = d;
    endtask

    task automatic test_read;
        int ph; logic act;
        run_access(1'b1, 1'b0, 32'd1028, $urandom, 1, NC);
        for (int c = 0; c < NC; c++) begin
            ph = phase_of(c, W); act = (ph == 1 || ph == 2);
            cmp_cnt++; if (tr_oe[c] !== !act || tr_we[c] !== 1'b1 || tr_dqoe[c] !== 1'b0) begin
                err_cnt++; $display("FAIL read_strobes c=%0d got oe_n=%b we_n=%b dqoe=%b", c, tr_oe[c], tr_we[c], tr_dqoe[c]); end
        end
        cmp_cnt++; if (tr_rd[NC-1] !== 32'hDEADBEEF) begin
            err_cnt++; $display("FAIL read_data got %h want deadbeef", tr_rd[NC-1]); end
        ref_rd = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk); #2;
            cmp_cnt++; if (read_data !== ref_rd || ready !== 1'b1) begin
                err_cnt++; $display("FAIL read_hold got %h rdy=%b want %h/1", read_data, ready, ref_rd); end
        end
    endtask

    task automatic test_both;
        int k = $urandom_range(2, 255);
        logic [31:0] d = $urandom;
        int nwe = 0;
        run_access(1'b1, 1'b1, 32'(BASE + 4 * k), d, 1, NC);
        for (int c = 0; c < NC; c++) if (!tr_we[c] && tr_oe[c]) nwe++;
        cmp_cnt++; if (nwe !== 2 * W) begin err_cnt++; $display("FAIL both_write_cycles got %0d want %0d", nwe, 2 * W); end
        cmp_cnt++; if (tr_rd[NC-1] !== ref_rd) begin
            err_cnt++; $display("FAIL both_rdata got %h want %h", tr_rd[NC-1], ref_rd); end
        model_mem[k] = d;
    endtask

    task automatic test_random;
        int k, hold, ph; logic rd, wr, act; logic [31:0] a, d;
        logic [16:0] wd;
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(0, 1));
            rd = !wr || ($urandom_range(0, 3) == 0);
            k = $urandom_range(0, 255);
            a = 32'(BASE + 4 * k + $urandom_range(0, 3));
            d = $urandom; hold = $urandom_range(1, 5);
            wd = word_of(a);
            run_access(rd, wr, a, d, hold, NC);
            for (int c = 0; c < NC; c++) begin
                ph = phase_of(c, W); act = (ph == 1 || ph == 2);
                cmp_cnt++; if (tr_ready[c] !== (ph == 3)) begin
                    err_cnt++; $display("FAIL rand_ready n=%0d c=%0d got %b", n, c, tr_ready[c]); end
                cmp_cnt++; if (tr_addr[c] !== (act ? {wd, ph == 2} : 18'd0)) begin
                    err_cnt++; $display("FAIL rand_addr n=%0d c=%0d got %h want %h", n, c, tr_addr[c], act ? {wd, ph == 2} : 18'd0); end
                cmp_cnt++; if (tr_we[c] !== !(act && wr) || tr_oe[c] !== !(act && !wr)) begin
                    err_cnt++; $display("FAIL rand_dir n=%0d c=%0d got we_n=%b oe_n=%b", n, c, tr_we[c], tr_oe[c]); end
                if (wr) begin
                    cmp_cnt++; if (tr_dqo[c] !== (ph == 1 ? d[15:0] : ph == 2 ? d[31:16] : 16'h0)) begin
                        err_cnt++; $display("FAIL rand_dq n=%0d c=%0d got %h", n, c, tr_dqo[c]); end
                end
            end
            if (wr) model_mem[k] = d;
            else    ref_rd = model_mem[k];
            cmp_cnt++; if (tr_rd[NC-1] !== ref_rd) begin
                err_cnt++; $display("FAIL rand_rdata n=%0d got %h want %h", n, tr_rd[NC-1], ref_rd); end
        end
    endtask

    task automatic test_wrap;
        run_access(1'b0, 1'b1, 32'(BASE - 4), $urandom, 1, NC);
        cmp_cnt++; if (tr_addr[1] !== 18'h3FFFE || tr_addr[W+1] !== 18'h3FFFF) begin
            err_cnt++; $display("FAIL wrap_addr got %h/%h want 3fffe/3ffff", tr_addr[1], tr_addr[W+1]); end
    endtask

    task automatic test_reset_mid;
        int k = $urandom_range(2, 255);
        logic [31:0] d = $urandom;
        logic [31:0] old = model_mem[k];
        @(negedge clk); w_en = 1'b1; address = 32'(BASE + 4 * k); write_data = d;
        @(negedge clk); w_en = 1'b0; address = $urandom;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; #2;           // first HIGH cycle
        cmp_cnt++; if (we_n !== 1'b1 || ce_n !== 1'b1 || dq_oe !== 1'b0) begin
            err_cnt++; $display("FAIL rstmid_during got we_n=%b ce_n=%b oe=%b want 1/1/0", we_n, ce_n, dq_oe); end
        @(negedge clk); rst = 1'b0; #2;
        cmp_cnt++; if (ready !== 1'b1 || {ce_n, oe_n, we_n, ub_n, lb_n} !== 5'h1F || sram_addr !== 18'd0) begin
            err_cnt++; $display("FAIL rstmid_after got rdy=%b strb=%b addr=%h", ready, {ce_n, oe_n, we_n, ub_n, lb_n}, sram_addr); end
        cmp_cnt++; if (read_data !== 32'd0) begin err_cnt++; $display("FAIL rstmid_rdata got %h want 0", read_data); end
        model_mem[k] = {old[31:16], d[15:0]};
        run_access(1'b1, 1'b0, 32'(BASE + 4 * k), $urandom, 1, NC);
        cmp_cnt++; if (tr_rd[NC-1] !== model_mem[k]) begin
            err_cnt++; $display("FAIL rstmid_halves got %h want %h", tr_rd[NC-1], model_mem[k]); end
        ref_rd = model_mem[k];
    endtask

    task automatic test_back_to_back;
        logic [16:0] wd = '0;
        int k;
        @(negedge clk); r_en1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            k = $urandom_range(0, 4095);
            address1 = 32'(BASE + 4 * k);
            if (c % 4 == 0) wd = 17'(k);
            #2;
            cmp_cnt++; if (ready1 !== (c % 4 == 3)) begin
                err_cnt++; $display("FAIL b2b_ready c=%0d got %b want %b", c, ready1, c % 4 == 3); end
            cmp_cnt++; if (oe_n1 !== !(c % 4 == 1 || c % 4 == 2)) begin
                err_cnt++; $display("FAIL b2b_oe c=%0d got %b", c, oe_n1); end
            if (c % 4 == 1 || c % 4 == 2) begin
                cmp_cnt++; if (sram_addr1 !== {wd, c % 4 == 2}) begin
                    err_cnt++; $display("FAIL b2b_addr c=%0d got %h want %h", c, sram_addr1, {wd, c % 4 == 2}); end
            end
            if (c % 4 == 3) begin
                cmp_cnt++; if (read_data1 !== {init_half({wd, 1'b1}), init_half({wd, 1'b0})}) begin
                    err_cnt++; $display("FAIL b2b_rdata c=%0d got %h want %h", c, read_data1,
                                        {init_half({wd, 1'b1}), init_half({wd, 1'b0})}); end
            end
        end
        r_en1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; r_en = 1'b1; w_en = 1'b0; address = 32'(BASE); write_data = '0;
        r_en1 = 1'b0; w_en1 = 1'b0; address1 = 32'(BASE); write_data1 = '0;
        pad_clr = 1'b1; ref_rd = '0;
        for (int i = 0; i < 256; i++)
            model_mem[i] = {init_half(18'(2 * i + 1)), init_half(18'(2 * i))};
        test_reset;
        test_write;
        test_read;
        test_both;
        test_random;
        test_wrap;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
